fir_mac_sequencer: RTL and testbench



---
 rtl/fir_mac_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared multiply-accumulate walks NTAPS taps per
// accepted sample, with a runtime-loadable coefficient bank and saturating output.
module fir_mac_sequencer #(
    parameter int SAMPLE_W = 3,
    parameter int COEF_W   = 3,
    parameter int NTAPS    = 8,
    parameter int OUT_W    = 10,
    parameter int ACC_W    = SAMPLE_W + COEF_W + $clog2(NTAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [SAMPLE_W-1:0]      signal,
    input  logic                     cfg_we,
    input  logic [$clog2(NTAPS)-1:0] cfg_addr,
    input  logic [COEF_W-1:0]        cfg_data,
    output logic [OUT_W-1:0]         result,
    output logic                     result_valid,
    output logic                     busy
);

    localparam int IDX_W  = $clog2(NTAPS);
    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [SAMPLE_W-1:0]  hist_r [NTAPS];
    logic [COEF_W-1:0]    coef_r [NTAPS];
    logic [ACC_W-1:0]     acc_r;
    logic [IDX_W-1:0]     idx_r;
    logic [OUT_W-1:0]     result_r;
    logic                 result_valid_r;
    logic                 busy_r;
    logic                 s_ready_r;

    logic                 accept_s;
    logic                 last_s;
    logic                 cfg_ok_s;
    logic [PROD_W-1:0]    prod_s;
    logic [ACC_W-1:0]     sum_s;

    // Clamp the accumulated sum into the output range.
    function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W-1:0] v);
        logic [SAT_W-1:0] wide;
        logic [SAT_W-1:0] limit;
        wide  = SAT_W'(v);
        limit = SAT_W'({OUT_W{1'b1}});
        if (wide > limit) begin
            saturate = {OUT_W{1'b1}};
        end else begin
            saturate = OUT_W'(wide);
        end
    endfunction

    assign accept_s = s_valid && s_ready_r;
    assign last_s   = (state_r == MAC) && (idx_r == LAST_IDX);
    assign cfg_ok_s = cfg_we && (state_r != MAC) && (32'(cfg_addr) < NTAPS);
    assign prod_s   = PROD_W'(hist_r[idx_r]) * PROD_W'(coef_r[idx_r]);
    assign sum_s    = acc_r + ACC_W'(prod_s);

    // Next-state decode; a sample offered during DONE chains straight into MAC.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = MAC;
                end else begin
                    state_s = IDLE;
                end
            end
            MAC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = MAC;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_s = MAC;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus handshake/status flags registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            s_ready_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s == MAC);
            s_ready_r <= (state_s != MAC);
        end
    end

    // Sample history: shifts only on accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                hist_r[k] <= {SAMPLE_W{1'b0}};
            end
        end else if (accept_s) begin
            hist_r[0] <= signal;
            for (int k = 1; k < NTAPS; k++) begin
                hist_r[k] <= hist_r[k-1];
            end
        end
    end

    // Coefficient bank: reset to unity taps, writable only outside MAC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef_r[k] <= COEF_W'(1'b1);
            end
        end else if (cfg_ok_s) begin
            coef_r[cfg_addr] <= cfg_data;
        end
    end

    // Accumulator and tap index sequencing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r <= {ACC_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            acc_r <= {ACC_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (last_s) begin
            acc_r <= sum_s;
            idx_r <= {IDX_W{1'b0}};
        end else if (state_r == MAC) begin
            acc_r <= sum_s;
            idx_r <= idx_r + IDX_W'(1'b1);
        end
    end

    // Result capture on the final tap; the value holds until the next capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_r       <= {OUT_W{1'b0}};
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= last_s;
            if (last_s) begin
                result_r <= saturate(sum_s);
            end
        end
    end

    assign s_ready      = s_ready_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: default (NTAPS=8), NTAPS=5 and NTAPS=32
// instances share stimulus; each scenario task checks its own expectations.
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [2:0] signal = 3'd0;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_addr = 5'd0;
    logic [2:0] cfg_data = 3'd0;

    logic       sr8, rv8, busy8;
    logic [9:0] result8;
    logic       sr5, rv5, busy5;
    logic [9:0] result5;
    logic       sr32, rv32, busy32;
    logic [9:0] result32;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_sequencer u8 (
        .i_clk(clk), .i_rst_n(rst_n), .s_valid(s_valid), .s_ready(sr8),
        .signal(signal), .cfg_we(cfg_we), .cfg_addr(cfg_addr[2:0]), .cfg_data(cfg_data),
        .result(result8), .result_valid(rv8), .busy(busy8)
    );

    fir_mac_sequencer #(.NTAPS(5)) u5 (
        .i_clk(clk), .i_rst_n(rst_n), .s_valid(s_valid), .s_ready(sr5),
        .signal(signal), .cfg_we(cfg_we), .cfg_addr(cfg_addr[2:0]), .cfg_data(cfg_data),
        .result(result5), .result_valid(rv5), .busy(busy5)
    );

    fir_mac_sequencer #(.NTAPS(32)) u32 (
        .i_clk(clk), .i_rst_n(rst_n), .s_valid(s_valid), .s_ready(sr32),
        .signal(signal), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .result(result32), .result_valid(rv32), .busy(busy32)
    );

    task automatic reset_all();
        rst_n = 1'b0; s_valid = 1'b0; cfg_we = 1'b0;
        signal = 3'd0; cfg_addr = 5'd0; cfg_data = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = 3'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Drive one sample into u8; cfg_mode 1 writes with the accept, 2 writes mid-MAC.
    task automatic feed8(input logic [2:0] smp, input int cfg_mode, input int a, input int d,
                         output int lat, output int lo, output int at, output logic [9:0] res);
        @(negedge clk);
        s_valid = 1'b1; signal = smp;
        for (int g = 0; g < 40 && !sr8; g++) @(negedge clk);
        if (cfg_mode == 1) begin
            cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = 3'(d);
        end
        @(posedge clk); #1;
        at = cyc;
        s_valid = 1'b0; cfg_we = 1'b0;
        lat = -1; lo = 0; res = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (!sr8) lo++;
            if (cfg_mode == 2 && n == 3) begin
                cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = 3'(d);
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk); #1;
            if (rv8) begin
                lat = n; res = result8;
                break;
            end
        end
        cfg_we = 1'b0;
    endtask

    // Drive one sample into the NTAPS=5 (which==5) or NTAPS=32 instance.
    task automatic feed_n(input int which, input logic [2:0] smp, output logic [9:0] res);
        @(negedge clk);
        s_valid = 1'b1; signal = smp;
        for (int g = 0; g < 40 && !((which == 5) ? sr5 : sr32); g++) @(negedge clk);
        @(posedge clk); #1;
        s_valid = 1'b0;
        res = 'x;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if ((which == 5) ? rv5 : rv32) begin
                res = (which == 5) ? result5 : result32;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_all();
        #1;
        compared++; if (result8 !== 10'd0) begin mismatched++; $display("FAIL reset_result: got %0d want 0", result8); end
        compared++; if (rv8 !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", rv8); end
        compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy8); end
        compared++; if (sr8 !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %0b want 1", sr8); end
    endtask

    task automatic test_default();
        int lat, lo, at;
        logic [9:0] res;
        reset_all();
        feed8(3'd6, 0, 0, 0, lat, lo, at, res);
        compared++; if (lat !== 8) begin mismatched++; $display("FAIL default_latency: got %0d want 8", lat); end
        compared++; if (res !== 10'd6) begin mismatched++; $display("FAIL default_first: got %0d want 6", res); end
        @(posedge clk); #1;
        compared++; if (rv8 !== 1'b0) begin mismatched++; $display("FAIL valid_one_cycle: got %0b want 0", rv8); end
        compared++; if (result8 !== 10'd6) begin mismatched++; $display("FAIL result_hold: got %0d want 6", result8); end
        compared++; if (sr8 !== 1'b1) begin mismatched++; $display("FAIL idle_ready: got %0b want 1", sr8); end
        feed8(3'd4, 0, 0, 0, lat, lo, at, res);
        compared++; if (res !== 10'd10) begin mismatched++; $display("FAIL default_second: got %0d want 10", res); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] smp [9] = '{3'd6, 3'd4, 3'd1, 3'd5, 3'd2, 3'd5, 3'd1, 3'd0, 3'd7};
        int         exp [9] = '{6, 10, 11, 16, 18, 23, 24, 24, 25};
        int lat, lo, at, prev_at;
        logic [9:0] res;
        reset_all();
        prev_at = 0;
        for (int i = 0; i < 9; i++) begin
            feed8(smp[i], 0, 0, 0, lat, lo, at, res);
            compared++; if (res !== 10'(exp[i])) begin mismatched++; $display("FAIL b2b_result[%0d]: got %0d want %0d", i, res, exp[i]); end
            compared++; if (lo !== 8) begin mismatched++; $display("FAIL b2b_ready_low[%0d]: got %0d want 8", i, lo); end
            if (i > 0) begin
                compared++; if (at - prev_at !== 9) begin mismatched++; $display("FAIL b2b_spacing[%0d]: got %0d want 9", i, at - prev_at); end
            end
            prev_at = at;
        end
    endtask

    task automatic test_coef_and_reset();
        int lat, lo, at, pulses;
        logic [9:0] res;
        reset_all();
        for (int k = 0; k < 8; k++) write_coef(k, 7);
        for (int i = 0; i < 8; i++) begin
            feed8(3'd7, 0, 0, 0, lat, lo, at, res);
            compared++; if (res !== 10'(49 * (i + 1))) begin mismatched++; $display("FAIL coef7_result[%0d]: got %0d want %0d", i, res, 49 * (i + 1)); end
        end
        @(negedge clk);
        s_valid = 1'b1; signal = 3'd7;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %0b want 0", busy8); end
        compared++; if (sr8 !== 1'b1) begin mismatched++; $display("FAIL midreset_ready: got %0b want 1", sr8); end
        compared++; if (result8 !== 10'd0) begin mismatched++; $display("FAIL midreset_result: got %0d want 0", result8); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (rv8) pulses++;
        end
        compared++; if (pulses !== 0) begin mismatched++; $display("FAIL midreset_pulses: got %0d want 0", pulses); end
        feed8(3'd3, 0, 0, 0, lat, lo, at, res);
        compared++; if (res !== 10'd3) begin mismatched++; $display("FAIL midreset_revert: got %0d want 3", res); end
    endtask

    task automatic test_cfg_timing();
        int lat, lo, at;
        logic [9:0] res;
        reset_all();
        feed8(3'd1, 0, 0, 0, lat, lo, at, res);
        feed8(3'd2, 0, 0, 0, lat, lo, at, res);
        feed8(3'd3, 0, 0, 0, lat, lo, at, res);
        compared++; if (res !== 10'd6) begin mismatched++; $display("FAIL cfg_prefill: got %0d want 6", res); end
        feed8(3'd4, 2, 3, 0, lat, lo, at, res);
        compared++; if (res !== 10'd10) begin mismatched++; $display("FAIL cfg_busy_ignored: got %0d want 10", res); end
        feed8(3'd5, 1, 3, 0, lat, lo, at, res);
        compared++; if (res !== 10'd13) begin mismatched++; $display("FAIL cfg_with_accept: got %0d want 13", res); end
    endtask

    task automatic test_addr_range();
        logic [9:0] res;
        reset_all();
        write_coef(7, 0);
        write_coef(5, 0);
        for (int i = 0; i < 5; i++) feed_n(5, 3'd2, res);
        compared++; if (res !== 10'd10) begin mismatched++; $display("FAIL addr_out_of_range: got %0d want 10", res); end
    endtask

    task automatic test_saturate();
        logic [9:0] res;
        reset_all();
        for (int k = 0; k < 32; k++) write_coef(k, 7);
        for (int i = 0; i < 32; i++) begin
            feed_n(32, 3'd7, res);
            if (i == 19) begin
                compared++; if (res !== 10'd980) begin mismatched++; $display("FAIL sat_below: got %0d want 980", res); end
            end
            if (i == 20) begin
                compared++; if (res !== 10'd1023) begin mismatched++; $display("FAIL sat_first: got %0d want 1023", res); end
            end
        end
        compared++; if (res !== 10'd1023) begin mismatched++; $display("FAIL sat_final: got %0d want 1023", res); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_back_to_back();
        test_coef_and_reset();
        test_cfg_timing();
        test_addr_range();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
